// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Two-port round-robin arbiter in front of a combinational-read instruction
// ROM. Port 0 is the fetch unit, port 1 is the debug/loader path. Each access
// takes two cycles. In the first cycle the owner is granted and the latched
// address is driven to the ROM. On the edge that ends it, the ROM word is
// captured into the owner's rdata register and rvalid pulses. Because one
// idle cycle sits between accesses, peak throughput is one access per two
// cycles.
//
// Parameters
//   N   instruction word width
//   CW  width of each saturating per-port completion counter
//
// Ports
//   clk              clock, rising edge
//   reset            asynchronous, active-low reset
//   req0/req1        access request (held until the port sees rvalid)
//   addr0/addr1      word address for the matching port
//   gnt0/gnt1        port owns the memory this cycle
//   rdata0/rdata1    last word returned to the port
//   rvalid0/rvalid1  one-cycle pulse marking new rdata
//   mem_addr         address to the ROM (always the latched address)
//   mem_q            ROM data for mem_addr, valid in the same cycle
//   cnt0/cnt1        completed accesses per port, saturating
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [5:0]    addr0,
    input  logic [5:0]    addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [N-1:0]  rdata0,
    output logic [N-1:0]  rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [5:0]    mem_addr,
    input  logic [N-1:0]  mem_q,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t          state_r, state_s;
    logic            owner_r, owner_s;
    logic            last_r, last_s;
    logic            win_s;
    logic [5:0]      addr_r, addr_s;
    logic            gnt0_r, gnt0_s, gnt1_r, gnt1_s;
    logic            rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
    logic [N-1:0]    rdata0_r, rdata0_s, rdata1_r, rdata1_s;
    logic [CW-1:0]   cnt0_r, cnt0_s, cnt1_r, cnt1_s;

    // Round-robin pick: on a tie the port that was not served last wins;
    // otherwise the sole requester wins (req1 alone -> 1, req0 alone -> 0).
    always_comb begin
        win_s = 1'b0;
        if (req0 && req1) begin
            win_s = ~last_r;
        end else begin
            win_s = req1;
        end
    end

    // Next-state and next-value logic; everything holds unless changed below.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        last_s    = last_r;
        addr_s    = addr_r;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        rvalid0_s = 1'b0;
        rvalid1_s = 1'b0;
        rdata0_s  = rdata0_r;
        rdata1_s  = rdata1_r;
        cnt0_s    = cnt0_r;
        cnt1_s    = cnt1_r;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    state_s = BUSY;
                    owner_s = win_s;
                    if (win_s) begin
                        addr_s = addr1;
                        gnt1_s = 1'b1;
                    end else begin
                        addr_s = addr0;
                        gnt0_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // Addresses are ignored here; addr_r was captured on entry.
                state_s = IDLE;
                last_s  = owner_r;
                if (owner_r) begin
                    rdata1_s  = mem_q;
                    rvalid1_s = 1'b1;
                    cnt1_s    = sat_inc(cnt1_r);
                end else begin
                    rdata0_s  = mem_q;
                    rvalid0_s = 1'b1;
                    cnt0_s    = sat_inc(cnt0_r);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; last resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            addr_r    <= 6'd0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= {N{1'b0}};
            rdata1_r  <= {N{1'b0}};
            cnt0_r    <= {CW{1'b0}};
            cnt1_r    <= {CW{1'b0}};
        end else begin
            owner_r   <= owner_s;
            last_r    <= last_s;
            addr_r    <= addr_s;
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            rvalid0_r <= rvalid0_s;
            rvalid1_r <= rvalid1_s;
            rdata0_r  <= rdata0_s;
            rdata1_r  <= rdata1_s;
            cnt0_r    <= cnt0_s;
            cnt1_r    <= cnt1_s;
        end
    end

    assign gnt0     = gnt0_r;
    assign gnt1     = gnt1_r;
    assign rvalid0  = rvalid0_r;
    assign rvalid1  = rvalid1_r;
    assign rdata0   = rdata0_r;
    assign rdata1   = rdata1_r;
    assign mem_addr = addr_r;
    assign cnt0     = cnt0_r;
    assign cnt1     = cnt1_r;

endmodule
